// File: rtl/mips_pkg.sv
// Shared definitions for the pipeline controller slice.
// Contents:
//   - opcode constants for the supported instruction set
//   - ALU control codes used by immediate forms
//   - stage_t: the control bundle carried through EX, MEM and WB
//   - pipe_state_e: halt sequencing states
//   - is_rtype(): true for the register-register opcodes
package mips_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_SLT = 3'd4;

  // Control bundle for one instruction; an all-zero value is a bubble.
  typedef struct packed {
    logic       valid;
    logic       src_imm;
    logic       branch;
    logic       branch_type;
    logic [2:0] alu;
    logic       mem_rd;
    logic       mem_wr;
    logic       we;
    logic       sel_mem;
    logic       halt;
    logic [4:0] dst;
  } stage_t;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_HALTED  = 2'd2
  } pipe_state_e;

  function automatic logic is_rtype(input logic [5:0] op);
    return op <= OP_MUL;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake and stage-bundle bus between the instruction source and the
// pipeline controller.
// Ports (signals):
//   id_valid/id_instr/id_ready  ID handshake
//   br_taken/flush              branch resolution and fetch redirect
//   ex_*, mem_*, wb_*           per-stage control bundles
//   halted                      sticky halt indication
// Modports: master drives the ID side and branch outcome, slave is the
// controller.
interface pipe_ctrl_if #(
  parameter int ALUW = 5,
  parameter int REGW = 5
);

  logic            id_valid;
  logic [31:0]     id_instr;
  logic            id_ready;
  logic            br_taken;
  logic            flush;
  logic            ex_valid;
  logic            ex_src_imm;
  logic            ex_branch;
  logic            ex_branch_type;
  logic [ALUW-1:0] ex_alu_ctrl;
  logic            mem_valid;
  logic            mem_rd;
  logic            mem_wr;
  logic            wb_valid;
  logic            wb_we;
  logic            wb_sel_mem;
  logic [REGW-1:0] wb_dst;
  logic            halted;

  modport master (
    output id_valid, id_instr, br_taken,
    input  id_ready, flush, ex_valid, ex_src_imm, ex_branch, ex_branch_type,
           ex_alu_ctrl, mem_valid, mem_rd, mem_wr, wb_valid, wb_we,
           wb_sel_mem, wb_dst, halted
  );

  modport slave (
    input  id_valid, id_instr, br_taken,
    output id_ready, flush, ex_valid, ex_src_imm, ex_branch, ex_branch_type,
           ex_alu_ctrl, mem_valid, mem_rd, mem_wr, wb_valid, wb_we,
           wb_sel_mem, wb_dst, halted
  );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder.
// Ports:
//   instr_i    32-bit instruction (opcode [31:26], rs, rt, rd)
//   dec_o      control bundle; all zero for unsupported opcodes
//   rs_o/rt_o  source register indices
//   rt_read_o  the instruction reads rt as a source (register-register forms)
//   is_hlt_o   the opcode is the halt opcode
module ctrl_decode
  import mips_pkg::*;
#(
  parameter logic [5:0] HLT_OP = 6'b111111
) (
  input  logic [31:0] instr_i,
  output stage_t      dec_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic        rt_read_o,
  output logic        is_hlt_o
);

  logic [5:0] op;
  logic [4:0] rd;
  logic       writes;
  logic       unused_funct;

  assign op           = instr_i[31:26];
  assign rs_o         = instr_i[25:21];
  assign rt_o         = instr_i[20:16];
  assign rd           = instr_i[15:11];
  assign rt_read_o    = is_rtype(op);
  assign is_hlt_o     = (op == HLT_OP);
  assign unused_funct = ^instr_i[10:0];

  // Non-writing instructions keep dst at 0, and a zero destination never
  // writes, so register 0 can never look like a hazard source.
  always_comb begin
    dec_o  = '0;
    writes = 1'b0;
    if (op == HLT_OP) begin
      dec_o.valid = 1'b1;
      dec_o.halt  = 1'b1;
    end else if (is_rtype(op)) begin
      dec_o.valid = 1'b1;
      dec_o.alu   = op[2:0];
      dec_o.dst   = rd;
      writes      = 1'b1;
    end else begin
      case (op)
        OP_LW: begin
          dec_o.valid   = 1'b1;
          dec_o.mem_rd  = 1'b1;
          dec_o.sel_mem = 1'b1;
          dec_o.dst     = rt_o;
          writes        = 1'b1;
        end
        OP_SW: begin
          dec_o.valid  = 1'b1;
          dec_o.mem_wr = 1'b1;
        end
        OP_ADDI: begin
          dec_o.valid = 1'b1;
          dec_o.alu   = ALU_ADD;
          dec_o.dst   = rt_o;
          writes      = 1'b1;
        end
        OP_SUBI: begin
          dec_o.valid = 1'b1;
          dec_o.alu   = ALU_SUB;
          dec_o.dst   = rt_o;
          writes      = 1'b1;
        end
        OP_SLTI: begin
          dec_o.valid = 1'b1;
          dec_o.alu   = ALU_SLT;
          dec_o.dst   = rt_o;
          writes      = 1'b1;
        end
        OP_BNEQZ: begin
          dec_o.valid  = 1'b1;
          dec_o.branch = 1'b1;
        end
        OP_BEQZ: begin
          dec_o.valid       = 1'b1;
          dec_o.branch      = 1'b1;
          dec_o.branch_type = 1'b1;
        end
        default: ;
      endcase
    end
    dec_o.src_imm = dec_o.valid & op[3];
    dec_o.we      = writes & (dec_o.dst != 5'd0);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: ID/EX, EX/MEM and MEM/WB control registers,
// load-use interlock, taken-branch flush and halt sequencing.
// Ports:
//   clk     clock
//   rst_n   asynchronous active-low reset
//   bus     pipe_ctrl_if slave: ID handshake, branch outcome, stage bundles,
//           halted
module pipe_ctrl
  import mips_pkg::*;
#(
  parameter int         ALUW      = 5,
  parameter int         REGW      = 5,
  parameter bit         INTERLOCK = 1'b1,
  parameter logic [5:0] HLT_OP    = 6'b111111
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  bus
);

  stage_t      dec;
  stage_t      ex_d, ex_q, mem_q, wb_q;
  pipe_state_e state_d, state_q;
  logic [4:0]  rs, rt;
  logic        rt_read, is_hlt;
  logic        stall, flush_w, id_ready_w, accept;
  logic        unused_wb;

  ctrl_decode #(.HLT_OP(HLT_OP)) u_decode (
    .instr_i   (bus.id_instr),
    .dec_o     (dec),
    .rs_o      (rs),
    .rt_o      (rt),
    .rt_read_o (rt_read),
    .is_hlt_o  (is_hlt)
  );

  // A load in EX has no data until MEM, so a dependent ID instruction waits
  // one cycle; by then the load has moved on and the hazard is gone.
  always_comb begin
    stall = INTERLOCK && ex_q.valid && ex_q.mem_rd && (ex_q.dst != 5'd0) &&
            bus.id_valid &&
            ((rs == ex_q.dst) || (rt_read && (rt == ex_q.dst)));
  end

  assign flush_w    = ex_q.valid & ex_q.branch & bus.br_taken;
  assign id_ready_w = (state_q == ST_RUN) & ~stall & ~flush_w;
  assign accept     = bus.id_valid & id_ready_w;
  assign ex_d       = accept ? dec : '0;

  // DRAIN ends on the edge that moves the halt into WB, so halted rises in
  // the same cycle the halt retires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (accept && is_hlt) state_d = ST_DRAIN;
      ST_DRAIN:  if (mem_q.valid && mem_q.halt) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= ST_RUN;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      state_q <= state_d;
    end
  end

  assign bus.id_ready       = id_ready_w;
  assign bus.flush          = flush_w;
  assign bus.ex_valid       = ex_q.valid;
  assign bus.ex_src_imm     = ex_q.src_imm;
  assign bus.ex_branch      = ex_q.branch;
  assign bus.ex_branch_type = ex_q.branch_type;
  assign bus.ex_alu_ctrl    = ALUW'(ex_q.alu);
  assign bus.mem_valid      = mem_q.valid;
  assign bus.mem_rd         = mem_q.mem_rd;
  assign bus.mem_wr         = mem_q.mem_wr;
  assign bus.wb_valid       = wb_q.valid;
  assign bus.wb_we          = wb_q.we;
  assign bus.wb_sel_mem     = wb_q.sel_mem;
  assign bus.wb_dst         = REGW'(wb_q.dst);
  assign bus.halted         = (state_q == ST_HALTED);

  assign unused_wb = ^{wb_q.src_imm, wb_q.branch, wb_q.branch_type, wb_q.alu,
                       wb_q.mem_rd, wb_q.mem_wr, wb_q.halt};

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios plus a randomized phase, all
// checked against a cycle-level model of the instruction pipeline.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        idValid;
  logic [31:0] idInstr;
  logic        brTaken;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.ALUW(5), .REGW(5)) bus0 ();
  pipe_ctrl_if #(.ALUW(5), .REGW(5)) bus1 ();

  assign bus0.id_valid = idValid;
  assign bus0.id_instr = idInstr;
  assign bus0.br_taken = brTaken;
  assign bus1.id_valid = idValid;
  assign bus1.id_instr = idInstr;
  assign bus1.br_taken = brTaken;

  pipe_ctrl #(.ALUW(5), .REGW(5), .INTERLOCK(1'b1), .HLT_OP(6'b111111)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  pipe_ctrl #(.ALUW(5), .REGW(5), .INTERLOCK(1'b0), .HLT_OP(6'b111111)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  typedef struct {
    bit valid;
    bit srcImm;
    bit branch;
    bit brType;
    int alu;
    bit memRd;
    bit memWr;
    bit we;
    bit selMem;
    bit hlt;
    int dst;
  } tbStage;

  tbStage mEx, mMem, mWb;
  bit     hltSeen, mHalted;
  int     cycle;
  int     compared = 0;
  int     mismatched = 0;
  logic   lastReady, lastReady1, lastFlush;

  // Expected decode, written straight from the instruction table.
  function automatic tbStage expectDecode(input logic [31:0] ins);
    tbStage     s;
    logic [5:0] op;
    int         rt, rd;
    s  = '{default: 0};
    op = ins[31:26];
    rt = int'(ins[20:16]);
    rd = int'(ins[15:11]);
    if (op == 6'b111111) begin
      s.valid = 1; s.hlt = 1; s.srcImm = 1;
    end else if (op <= 6'd5) begin
      s.valid = 1; s.alu = int'(op); s.dst = rd;
    end else begin
      case (op)
        6'b001000: begin s.valid = 1; s.memRd = 1; s.selMem = 1; s.dst = rt; end
        6'b001001: begin s.valid = 1; s.memWr = 1; end
        6'b001010: begin s.valid = 1; s.alu = 0; s.dst = rt; end
        6'b001011: begin s.valid = 1; s.alu = 1; s.dst = rt; end
        6'b001100: begin s.valid = 1; s.alu = 4; s.dst = rt; end
        6'b001101: begin s.valid = 1; s.branch = 1; end
        6'b001110: begin s.valid = 1; s.branch = 1; s.brType = 1; end
        default: ;
      endcase
      if (s.valid) s.srcImm = 1;
    end
    s.we = s.valid && !s.memWr && !s.branch && !s.hlt && (s.dst != 0);
    return s;
  endfunction

  function automatic bit readsReg(input logic [31:0] ins, input int r);
    return (int'(ins[25:21]) == r) || ((ins[31:26] <= 6'd5) && (int'(ins[20:16]) == r));
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] obsVec();
    return {9'd0, bus0.id_ready, bus0.flush, bus0.ex_valid, bus0.ex_src_imm,
            bus0.ex_branch, bus0.ex_branch_type, bus0.ex_alu_ctrl,
            bus0.mem_valid, bus0.mem_rd, bus0.mem_wr, bus0.wb_valid,
            bus0.wb_we, bus0.wb_sel_mem, bus0.wb_dst, bus0.halted};
  endfunction

  function automatic logic [31:0] expVec(input bit rdy, input bit fl);
    return {9'd0, rdy, fl, mEx.valid, mEx.srcImm, mEx.branch, mEx.brType,
            5'(mEx.alu), mMem.valid, mMem.memRd, mMem.memWr, mWb.valid,
            mWb.we, mWb.selMem, 5'(mWb.dst), mHalted};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mEx     = '{default: 0};
    mMem    = '{default: 0};
    mWb     = '{default: 0};
    hltSeen = 0;
    mHalted = 0;
  endtask

  // One clock cycle: drive inputs, compare everything mid-cycle, advance model.
  task automatic applyStimulus(input bit v, input logic [31:0] ins, input bit bt);
    bit     expFlush, expStall, expReady;
    tbStage nx;
    idValid = v;
    idInstr = ins;
    brTaken = bt;
    @(negedge clk);
    expFlush   = mEx.valid && mEx.branch && bt;
    expStall   = mEx.valid && mEx.memRd && (mEx.dst != 0) && v && readsReg(ins, mEx.dst);
    expReady   = !hltSeen && !expStall && !expFlush;
    lastReady  = bus0.id_ready;
    lastReady1 = bus1.id_ready;
    lastFlush  = bus0.flush;
    checkOutput($sformatf("cycle%0d", cycle), obsVec(), expVec(expReady, expFlush));
    nx = '{default: 0};
    if (v && expReady) begin
      nx = expectDecode(ins);
      if (ins[31:26] == 6'b111111) hltSeen = 1;
    end
    mWb  = mMem;
    mMem = mEx;
    mEx  = nx;
    if (mWb.valid && mWb.hlt) mHalted = 1;
    cycle++;
    @(posedge clk);
    #1;
  endtask

  logic [5:0] opList [14] = '{6'b000000, 6'b000001, 6'b000010, 6'b000011,
                              6'b000100, 6'b000101, 6'b001000, 6'b001001,
                              6'b001010, 6'b001011, 6'b001100, 6'b001101,
                              6'b001110, 6'b100000};

  initial begin
    logic [31:0] v;
    logic [31:0] addR5;
    cycle   = 0;
    rst_n   = 1'b0;
    idValid = 1'b0;
    idInstr = '0;
    brTaken = 1'b0;
    modelReset();
    $display("[TB] start");

    // Reset state, then an accept on the very first edge after release.
    @(posedge clk);
    #1;
    v = obsVec(); v[22] = 1'b0;
    checkOutput("reset_state", v, 32'd0);
    rst_n = 1'b1;

    applyStimulus(1, mk(6'b000000, 5'd1, 5'd2, 5'd3), 0);
    checkOutput("add_first_accept", {31'd0, lastReady}, 32'd1);
    checkOutput("add_ex", {26'd0, bus0.ex_valid, bus0.ex_alu_ctrl}, {26'd0, 1'b1, 5'd0});
    applyStimulus(0, '0, 0);
    applyStimulus(0, '0, 0);
    checkOutput("add_wb", {25'd0, bus0.wb_valid, bus0.wb_we, bus0.wb_dst}, {25'd0, 1'b1, 1'b1, 5'd3});

    // Load-use: one stall cycle with INTERLOCK, none without.
    addR5 = mk(6'b000000, 5'd5, 5'd2, 5'd6);
    applyStimulus(1, mk(6'b001000, 5'd1, 5'd5, 5'd0), 0);
    applyStimulus(1, addR5, 0);
    checkOutput("lwuse_stall", {31'd0, lastReady}, 32'd0);
    checkOutput("nointerlock_no_stall", {31'd0, lastReady1}, 32'd1);
    checkOutput("stall_bubble", {31'd0, bus0.ex_valid}, 32'd0);
    applyStimulus(1, addR5, 0);
    checkOutput("lwuse_resolved", {31'd0, lastReady}, 32'd1);
    applyStimulus(0, '0, 0);
    applyStimulus(0, '0, 0);
    checkOutput("add_wb_after_stall", {25'd0, bus0.wb_valid, bus0.wb_we, bus0.wb_dst}, {25'd0, 1'b1, 1'b1, 5'd6});

    // Load into r0 creates no hazard and never writes.
    applyStimulus(1, mk(6'b001000, 5'd1, 5'd0, 5'd0), 0);
    applyStimulus(1, mk(6'b000000, 5'd0, 5'd0, 5'd7), 0);
    checkOutput("lw_r0_no_stall", {31'd0, lastReady}, 32'd1);
    applyStimulus(0, '0, 0);
    checkOutput("lw_r0_no_we", {29'd0, bus0.wb_valid, bus0.wb_we, bus0.wb_sel_mem}, {29'd0, 3'b101});

    // Taken branch squashes the ID instruction for exactly one cycle.
    applyStimulus(1, mk(6'b001110, 5'd4, 5'd0, 5'd0), 0);
    applyStimulus(1, mk(6'b000001, 5'd1, 5'd2, 5'd3), 1);
    checkOutput("branch_flush", {30'd0, lastFlush, lastReady}, {30'd0, 2'b10});
    checkOutput("sub_squashed", {31'd0, bus0.ex_valid}, 32'd0);
    applyStimulus(1, mk(6'b000011, 5'd1, 5'd2, 5'd4), 0);
    checkOutput("accept_after_flush", {30'd0, lastFlush, lastReady}, {30'd0, 2'b01});

    // Reset asserted mid-stall with a load sitting in MEM.
    applyStimulus(1, mk(6'b001000, 5'd1, 5'd7, 5'd0), 0);
    applyStimulus(1, mk(6'b001000, 5'd1, 5'd5, 5'd0), 0);
    idValid = 1'b1;
    idInstr = addR5;
    brTaken = 1'b0;
    #2;
    checkOutput("stall_before_reset", {29'd0, bus0.id_ready, bus0.mem_valid, bus0.mem_rd}, {29'd0, 3'b011});
    rst_n = 1'b0;
    #1;
    v = obsVec(); v[22] = 1'b0;
    checkOutput("reset_mid_stall", v, 32'd0);
    modelReset();
    @(posedge clk);
    #1;
    v = obsVec(); v[22] = 1'b0;
    checkOutput("reset_hold", v, 32'd0);
    rst_n = 1'b1;
    applyStimulus(1, addR5, 0);
    checkOutput("resume_accept", {31'd0, lastReady}, 32'd1);

    // Randomized traffic with a small register space to provoke hazards.
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    mk(opList[$urandom_range(0, 13)], 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))),
                    $urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < 3; i++) applyStimulus(0, '0, 0);

    // Halt: following instructions blocked, halted three cycles after accept.
    applyStimulus(1, 32'hFC00_0000, 0);
    checkOutput("hlt_accept", {31'd0, lastReady}, 32'd1);
    applyStimulus(1, mk(6'b000000, 5'd1, 5'd2, 5'd3), 0);
    checkOutput("hlt_blocks_add", {31'd0, lastReady}, 32'd0);
    checkOutput("halted_not_yet", {30'd0, bus0.halted, bus0.ex_valid}, 32'd0);
    applyStimulus(1, mk(6'b000000, 5'd1, 5'd2, 5'd3), 0);
    checkOutput("halted_at_3", {31'd0, bus0.halted}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, mk(6'b000000, 5'd1, 5'd2, 5'd3), 0);
      checkOutput("halted_ready_low", {31'd0, lastReady}, 32'd0);
    end
    checkOutput("halted_drained", {28'd0, bus0.ex_valid, bus0.mem_valid, bus0.wb_valid, bus0.halted}, {28'd0, 4'b0001});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
